// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer interrupt source:
// register map, CTRL field layout, mode codes and FSM state encoding.
package timer_pkg;

    // Word indices on the register port
    localparam logic [1:0] CTRL_IDX   = 2'd0;
    localparam logic [1:0] PRESET_IDX = 2'd1;
    localparam logic [1:0] COUNT_IDX  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // Mode codes; codes 2 and 3 are kept as written but act as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // CTRL register image, packed so that {im, mode, en} == CTRL[3:0]
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_irq_source.sv
// Memory-mapped countdown timer driving one CP0 HWInt request line.
// One-shot mode latches the flag until software rewrites CTRL; auto-reload
// mode produces a single-cycle request each period. A CPU write to CTRL
// always takes priority over the FSM's own updates of EN and the flag.
module timer_irq_source
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        WE,
    input  logic [1:0]  A,
    input  logic [31:0] D,
    output logic [31:0] Q,
    output logic        IRQ
);

    state_e             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flag_q, flag_d;

    // State and register file; reset abandons any count in progress
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Next state: FSM first, then CPU writes override CTRL and the flag
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    count_d = preset_q;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_CNT;
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d = '0;
                    flag_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                // Reload mode keeps EN so IDLE restarts the count next edge
                if (ctrl_q.mode == MODE_RELOAD) flag_d = 1'b0;
                else                            ctrl_d.en = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (WE) begin
            case (A)
                CTRL_IDX: begin
                    ctrl_d = ctrl_t'(D[CTRL_IM_BIT:CTRL_EN_BIT]);
                    flag_d = 1'b0;
                end
                PRESET_IDX: preset_d = D[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Combinational read mux, zero-extended to the bus width
    always_comb begin
        Q = '0;
        case (A)
            CTRL_IDX:   Q = 32'(ctrl_q);
            PRESET_IDX: Q = 32'(preset_q);
            COUNT_IDX:  Q = 32'(count_q);
            default:    Q = '0;
        endcase
    end

    assign IRQ = flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_irq_source.sv
// Randomised and directed bench for timer_irq_source with a timeline model:
// the model tracks edges elapsed since the last reload and derives COUNT and
// the flag from PRESET arithmetic rather than from a state machine.
module tb_timer_irq_source;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        WE;
    logic [1:0]  A;
    logic [31:0] D;
    logic [31:0] Q;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    timer_irq_source #(.CNT_W(32)) dut (
        .clk(clk), .RESET_N(RESET_N), .WE(WE), .A(A), .D(D), .Q(Q), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_t = 0 : idle; m_t = k>0 : k edges since the reload edge.
    // Expiry happens at t = 2+max(L,1); the next edge is the interrupt edge.
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_pre, m_cnt, m_L;
    longint      m_t;

    function automatic longint expire_t(logic [31:0] l);
        return 2 + ((l > 1) ? longint'(l) : 1);
    endfunction

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            m_en <= 0; m_im <= 0; m_flag <= 0; m_mode <= 0;
            m_pre <= 0; m_cnt <= 0; m_L <= 0; m_t <= 0;
        end else begin
            logic        n_en, n_im, n_flag;
            logic [1:0]  n_mode;
            logic [31:0] n_pre, n_cnt, n_L;
            longint      n_t, tx;
            n_en = m_en; n_im = m_im; n_flag = m_flag; n_mode = m_mode;
            n_pre = m_pre; n_cnt = m_cnt; n_L = m_L; n_t = m_t;
            tx = expire_t(m_L);
            if (m_t == 0) begin
                if (m_en) begin n_t = 1; n_L = m_pre; n_cnt = m_pre; end
            end else if (m_t == tx) begin
                if (m_mode == 2'd1) n_flag = 0; else n_en = 0;
                n_t = 0;
            end else if (m_t >= 2 && !m_en) begin
                n_t = 0;
            end else begin
                n_t = m_t + 1;
                if (n_t >= tx)      n_cnt = 0;
                else if (n_t <= 2)  n_cnt = m_L;
                else                n_cnt = m_L - 32'(n_t - 2);
                if (n_t == tx) n_flag = 1;
            end
            if (WE && A == 2'd0) begin
                n_en = D[0]; n_mode = D[2:1]; n_im = D[3]; n_flag = 0;
            end
            if (WE && A == 2'd1) n_pre = D;
            m_en <= n_en; m_im <= n_im; m_flag <= n_flag; m_mode <= n_mode;
            m_pre <= n_pre; m_cnt <= n_cnt; m_L <= n_L; m_t <= n_t;
        end
    end

    function automatic logic [31:0] model_q(logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_im, m_mode, m_en};
            2'd1:    return m_pre;
            2'd2:    return m_cnt;
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("Q_vs_model", Q, model_q(A));
        chk("IRQ_vs_model", {31'b0, IRQ}, {31'b0, m_flag & m_im});
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        WE = 1; A = a; D = d;
        @(posedge clk); #1;
        WE = 0;
    endtask

    task automatic rd_chk(string nm, logic [1:0] a, logic [31:0] exp);
        A = a; #1;
        chk(nm, Q, exp);
    endtask

    initial begin
        RESET_N = 0; WE = 0; A = 0; D = 0;
        idle(3);
        rd_chk("reset_ctrl", 2'd0, 32'h0);
        rd_chk("reset_count", 2'd2, 32'h0);
        chk("reset_irq", {31'b0, IRQ}, 32'h0);
        RESET_N = 1;
        idle(2);

        // Reset in the middle of a count
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h1);
        idle(20);
        rd_chk("count_before_reset", 2'd2, 32'd82);
        #2 RESET_N = 0;
        #1;
        chk("reset_mid_q", Q, 32'h0);
        chk("reset_mid_irq", {31'b0, IRQ}, 32'h0);
        idle(2);
        RESET_N = 1;
        idle(3);
        rd_chk("post_reset_ctrl", 2'd0, 32'h0);
        rd_chk("post_reset_count", 2'd2, 32'h0);

        // One-shot, PRESET=5: IRQ after E7, EN cleared, held until CTRL write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        idle(6);
        chk("oneshot_irq_E6", {31'b0, IRQ}, 32'h0);
        idle(1);
        chk("oneshot_irq_E7", {31'b0, IRQ}, 32'h1);
        idle(3);
        rd_chk("oneshot_ctrl_en_clr", 2'd0, 32'h8);
        chk("oneshot_irq_held", {31'b0, IRQ}, 32'h1);
        wr(2'd0, 32'h8);
        chk("oneshot_irq_ack", {31'b0, IRQ}, 32'h0);
        idle(3);

        // Auto-reload, PRESET=2: single-cycle pulses every 5 cycles from E4
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            idle(1);
            chk($sformatf("reload_E%0d", k), {31'b0, IRQ},
                {31'b0, (k >= 4 && (k - 4) % 5 == 0)});
        end
        wr(2'd0, 32'h0);
        idle(3);

        // Mask: flag latches with IM=0, CTRL write clears it
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        idle(5);
        chk("mask_irq_hidden", {31'b0, IRQ}, 32'h0);
        idle(1);
        wr(2'd0, 32'h8);
        chk("mask_write_clears", {31'b0, IRQ}, 32'h0);
        wr(2'd0, 32'h9);
        idle(4);
        chk("mask_irq_E4", {31'b0, IRQ}, 32'h0);
        idle(1);
        chk("mask_irq_E5", {31'b0, IRQ}, 32'h1);
        wr(2'd0, 32'h0);
        idle(3);

        // PRESET 0 and 1 both expire at E3
        for (int p = 0; p < 2; p++) begin
            wr(2'd1, 32'(p));
            wr(2'd0, 32'h9);
            idle(2);
            chk($sformatf("preset%0d_E2", p), {31'b0, IRQ}, 32'h0);
            idle(1);
            chk($sformatf("preset%0d_E3", p), {31'b0, IRQ}, 32'h1);
            wr(2'd0, 32'h0);
            idle(3);
        end

        // Maximum PRESET, EN cleared by a write at E9: COUNT frozen
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        idle(8);
        wr(2'd0, 32'h0);
        idle(3);
        rd_chk("max_preset_frozen", 2'd2, 32'hFFFF_FFF8);
        idle(2);
        rd_chk("max_preset_still", 2'd2, 32'hFFFF_FFF8);

        // Collision: CTRL write on the one-shot interrupt edge keeps EN
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        idle(6);
        chk("coll_flag_E6", {31'b0, IRQ}, 32'h1);
        wr(2'd0, 32'h9);
        chk("coll_irq_cleared", {31'b0, IRQ}, 32'h0);
        rd_chk("coll_ctrl_kept", 2'd0, 32'h9);
        rd_chk("coll_count_zero", 2'd2, 32'h0);
        idle(1);
        rd_chk("coll_reloaded", 2'd2, 32'h4);
        wr(2'd0, 32'h0);
        idle(3);

        // Writes to COUNT / reserved are ignored
        wr(2'd2, 32'h1234);
        wr(2'd3, 32'h5678);
        rd_chk("count_ro", 2'd2, 32'h4);
        rd_chk("reserved_zero", 2'd3, 32'h0);

        // Randomised traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            WE = 0; A = 2'($urandom_range(0, 3)); D = $urandom;
            if (r < 8) begin
                WE = 1; A = 2'd0;
            end else if (r < 16) begin
                WE = 1; A = 2'd1; D = 32'($urandom_range(0, 6));
            end else if (r < 20) begin
                WE = 1; A = 2'($urandom_range(2, 3));
            end
            @(posedge clk); #1;
        end
        WE = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
